// File: rtl/load_unit_cache_controller.sv
// Load-side cache controller: serves loads from cache port 1, refills missing
// blocks (evicting a dirty victim first) and bypasses the cache for
// non-cachable addresses. Results are byte/half/word aligned and extended.
module load_unit_cache_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int PORT_WIDTH  = 32,
    parameter int WAYS_NUMBER = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    kill_i,
    input  logic                    load_read_i,
    input  logic [ADDR_WIDTH-1:0]   load_address_i,
    input  logic                    load_cachable_i,
    input  logic [1:0]              load_width_i,
    input  logic                    load_signed_i,
    output logic [PORT_WIDTH-1:0]   load_data_o,
    output logic                    load_valid_o,
    output logic                    idle_o,
    output logic                    port1_request_o,
    input  logic                    cache_port1_granted_i,
    output logic                    cache_read_o,
    output logic                    cache_write_o,
    output logic [ADDR_WIDTH-3:0]   cache_address_o,
    output logic [3:0]              cache_enable_o,
    output logic [WAYS_NUMBER-1:0]  cache_enable_way_o,
    output logic [PORT_WIDTH-1:0]   cache_data_o,
    output logic                    cache_valid_o,
    output logic                    cache_dirty_o,
    input  logic                    cache_hit_i,
    input  logic [WAYS_NUMBER-1:0]  cache_way_valid_i,
    input  logic [WAYS_NUMBER-1:0]  cache_way_dirty_i,
    input  logic [PORT_WIDTH-1:0]   cache_data_i,
    output logic                    memory_evict_o,
    output logic [WAYS_NUMBER-1:0]  memory_evict_way_o,
    input  logic                    memory_evict_done_i,
    output logic                    memory_request_o,
    input  logic                    memory_acknowledge_i,
    output logic [ADDR_WIDTH-1:0]   memory_address_o,
    input  logic [PORT_WIDTH-1:0]   memory_data_i,
    input  logic                    memory_data_valid_i,
    output logic                    memory_ready_o
);

    localparam int WSEL = $clog2(BLOCK_WORDS);
    localparam int VW   = (WAYS_NUMBER > 1) ? $clog2(WAYS_NUMBER) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE_TAG,
        EVICT,
        MEM_REQUEST,
        REFILL,
        WAIT_WORD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              width_q, width_d;
    logic                    signed_q, signed_d;
    logic                    cachable_q, cachable_d;
    logic [WAYS_NUMBER-1:0]  victim_q, victim_d;
    logic [VW-1:0]           rr_q, rr_d;
    logic [WSEL-1:0]         word_cnt_q, word_cnt_d;
    logic                    kill_pending_q, kill_pending_d;
    logic [PORT_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;

    logic [WAYS_NUMBER-1:0]  invalid_onehot;
    logic [WAYS_NUMBER-1:0]  rr_onehot;
    logic [WAYS_NUMBER-1:0]  miss_victim;

    // Pick the requested byte/half/word lane and extend it to the port width.
    function automatic logic [PORT_WIDTH-1:0] align_word(
        input logic [PORT_WIDTH-1:0] w,
        input logic [1:0]            bsel,
        input logic [1:0]            width,
        input logic                  sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{bsel, 3'b000} +: 8];
        h = w[{bsel[1], 4'b0000} +: 16];
        case (width)
            2'd0:    return {{(PORT_WIDTH-8){sgn & b[7]}}, b};
            2'd1:    return {{(PORT_WIDTH-16){sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Victim choice on a miss: lowest invalid way first, otherwise round-robin.
    always_comb begin
        invalid_onehot = '0;
        for (int i = WAYS_NUMBER - 1; i >= 0; i--) begin
            if (!cache_way_valid_i[i]) begin
                invalid_onehot    = '0;
                invalid_onehot[i] = 1'b1;
            end
        end
        rr_onehot        = '0;
        rr_onehot[rr_q]  = 1'b1;
        miss_victim      = (|(~cache_way_valid_i)) ? invalid_onehot : rr_onehot;
    end

    // Next-state and output decode for the load transaction sequence.
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        width_d            = width_q;
        signed_d           = signed_q;
        cachable_d         = cachable_q;
        victim_d           = victim_q;
        rr_d               = rr_q;
        word_cnt_d         = word_cnt_q;
        kill_pending_d     = kill_pending_q;
        load_data_d        = load_data_q;
        load_valid_d       = 1'b0;
        port1_request_o    = 1'b0;
        cache_read_o       = 1'b0;
        cache_write_o      = 1'b0;
        cache_address_o    = '0;
        cache_enable_o     = 4'b0000;
        cache_enable_way_o = '0;
        cache_data_o       = '0;
        cache_valid_o      = 1'b0;
        cache_dirty_o      = 1'b0;
        memory_evict_o     = 1'b0;
        memory_evict_way_o = '0;
        memory_request_o   = 1'b0;
        memory_address_o   = '0;
        memory_ready_o     = 1'b0;

        case (state_q)
            IDLE: begin
                port1_request_o = load_read_i & load_cachable_i;
                cache_address_o = load_address_i[ADDR_WIDTH-1:2];
                kill_pending_d  = 1'b0;
                word_cnt_d      = '0;
                if (load_read_i && !kill_i) begin
                    if (!load_cachable_i || cache_port1_granted_i) begin
                        addr_d     = load_address_i;
                        width_d    = load_width_i;
                        signed_d   = load_signed_i;
                        cachable_d = load_cachable_i;
                    end
                    if (!load_cachable_i) begin
                        state_d = MEM_REQUEST;
                    end else if (cache_port1_granted_i) begin
                        cache_read_o   = 1'b1;
                        cache_enable_o = 4'b1111;
                        state_d        = COMPARE_TAG;
                    end
                end
            end
            COMPARE_TAG: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (cache_hit_i) begin
                    load_data_d  = align_word(cache_data_i, addr_q[1:0], width_q, signed_q);
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    victim_d = miss_victim;
                    rr_d     = (rr_q == VW'(WAYS_NUMBER - 1)) ? '0 : rr_q + 1'b1;
                    state_d  = (|(miss_victim & cache_way_valid_i & cache_way_dirty_i))
                               ? EVICT : MEM_REQUEST;
                end
            end
            EVICT: begin
                memory_evict_o     = 1'b1;
                memory_evict_way_o = victim_q;
                if (kill_i) kill_pending_d = 1'b1;
                if (memory_evict_done_i) state_d = MEM_REQUEST;
            end
            MEM_REQUEST: begin
                memory_request_o = 1'b1;
                memory_address_o = cachable_q
                                   ? {addr_q[ADDR_WIDTH-1:WSEL+2], {(WSEL+2){1'b0}}}
                                   : {addr_q[ADDR_WIDTH-1:2], 2'b00};
                if (kill_i) kill_pending_d = 1'b1;
                if (memory_acknowledge_i) state_d = cachable_q ? REFILL : WAIT_WORD;
            end
            REFILL: begin
                port1_request_o = 1'b1;
                memory_ready_o  = cache_port1_granted_i;
                cache_address_o = {addr_q[ADDR_WIDTH-1:WSEL+2], word_cnt_q};
                if (kill_i) kill_pending_d = 1'b1;
                if (cache_port1_granted_i && memory_data_valid_i) begin
                    cache_write_o      = 1'b1;
                    cache_enable_o     = 4'b1111;
                    cache_enable_way_o = victim_q;
                    cache_data_o       = memory_data_i;
                    cache_valid_o      = 1'b1;
                    cache_dirty_o      = 1'b0;
                    if (word_cnt_q == addr_q[WSEL+1:2]) begin
                        load_data_d = align_word(memory_data_i, addr_q[1:0], width_q, signed_q);
                    end
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WSEL'(BLOCK_WORDS - 1)) begin
                        load_valid_d = !(kill_pending_q | kill_i);
                        state_d      = IDLE;
                    end
                end
            end
            WAIT_WORD: begin
                memory_ready_o = 1'b1;
                if (kill_i) kill_pending_d = 1'b1;
                if (memory_data_valid_i) begin
                    load_data_d  = align_word(memory_data_i, addr_q[1:0], width_q, signed_q);
                    load_valid_d = !(kill_pending_q | kill_i);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            width_q        <= 2'd0;
            signed_q       <= 1'b0;
            cachable_q     <= 1'b0;
            victim_q       <= '0;
            rr_q           <= '0;
            word_cnt_q     <= '0;
            kill_pending_q <= 1'b0;
            load_data_q    <= '0;
            load_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            width_q        <= width_d;
            signed_q       <= signed_d;
            cachable_q     <= cachable_d;
            victim_q       <= victim_d;
            rr_q           <= rr_d;
            word_cnt_q     <= word_cnt_d;
            kill_pending_q <= kill_pending_d;
            load_data_q    <= load_data_d;
            load_valid_q   <= load_valid_d;
        end
    end

    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign idle_o       = (state_q == IDLE);

endmodule

// File: tb/tb_load_unit_cache_controller.sv
// Testbench for load_unit_cache_controller: the bench plays the cache arrays
// and the memory unit, and a scoreboard checks every returned load against
// a reference model of memory contents plus the replacement policy.
module tb_load_unit_cache_controller;

    localparam int AW    = 32;
    localparam int PW    = 32;
    localparam int WAYS  = 4;
    localparam int BW    = 4;
    localparam int NSETS = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            kill_i;
    logic            load_read_i;
    logic [AW-1:0]   load_address_i;
    logic            load_cachable_i;
    logic [1:0]      load_width_i;
    logic            load_signed_i;
    logic [PW-1:0]   load_data_o;
    logic            load_valid_o;
    logic            idle_o;
    logic            port1_request_o;
    logic            cache_port1_granted_i;
    logic            cache_read_o;
    logic            cache_write_o;
    logic [AW-3:0]   cache_address_o;
    logic [3:0]      cache_enable_o;
    logic [WAYS-1:0] cache_enable_way_o;
    logic [PW-1:0]   cache_data_o;
    logic            cache_valid_o;
    logic            cache_dirty_o;
    logic            cache_hit_i;
    logic [WAYS-1:0] cache_way_valid_i;
    logic [WAYS-1:0] cache_way_dirty_i;
    logic [PW-1:0]   cache_data_i;
    logic            memory_evict_o;
    logic [WAYS-1:0] memory_evict_way_o;
    logic            memory_evict_done_i;
    logic            memory_request_o;
    logic            memory_acknowledge_i;
    logic [AW-1:0]   memory_address_o;
    logic [PW-1:0]   memory_data_i;
    logic            memory_data_valid_i;
    logic            memory_ready_o;

    load_unit_cache_controller #(
        .ADDR_WIDTH(AW), .PORT_WIDTH(PW), .WAYS_NUMBER(WAYS), .BLOCK_WORDS(BW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .kill_i(kill_i),
        .load_read_i(load_read_i), .load_address_i(load_address_i),
        .load_cachable_i(load_cachable_i), .load_width_i(load_width_i),
        .load_signed_i(load_signed_i), .load_data_o(load_data_o),
        .load_valid_o(load_valid_o), .idle_o(idle_o),
        .port1_request_o(port1_request_o), .cache_port1_granted_i(cache_port1_granted_i),
        .cache_read_o(cache_read_o), .cache_write_o(cache_write_o),
        .cache_address_o(cache_address_o), .cache_enable_o(cache_enable_o),
        .cache_enable_way_o(cache_enable_way_o), .cache_data_o(cache_data_o),
        .cache_valid_o(cache_valid_o), .cache_dirty_o(cache_dirty_o),
        .cache_hit_i(cache_hit_i), .cache_way_valid_i(cache_way_valid_i),
        .cache_way_dirty_i(cache_way_dirty_i), .cache_data_i(cache_data_i),
        .memory_evict_o(memory_evict_o), .memory_evict_way_o(memory_evict_way_o),
        .memory_evict_done_i(memory_evict_done_i), .memory_request_o(memory_request_o),
        .memory_acknowledge_i(memory_acknowledge_i), .memory_address_o(memory_address_o),
        .memory_data_i(memory_data_i), .memory_data_valid_i(memory_data_valid_i),
        .memory_ready_o(memory_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference state: cache arrays, round-robin pointer, expected results.
    logic [25:0] tag_m  [NSETS][WAYS];
    bit          valid_m[NSETS][WAYS];
    bit          dirty_m[NSETS][WAYS];
    logic [31:0] data_m [NSETS][WAYS][BW];
    int          rr_m;
    logic [31:0] exp_q[$];
    int          vectors;
    int          miscompares;

    // Knobs for environment handshake randomness.
    int grant_pct, ack_pct, dv_pct, done_pct;
    bit hold_data;

    // Current load as seen by the environment.
    logic [31:0] cur_addr;
    bit          cur_cach;
    int          exp_victim;
    bit          exp_evict;
    bit          evict_seen;
    int          last_latency;

    // Environment bookkeeping.
    bit          rd_pend, cmp_cycle, cmp_hit, beat_taken;
    logic [29:0] rd_waddr, cmp_waddr;
    bit          mem_active, mem_cach;
    logic [31:0] mem_base;
    int          beat_idx, beats_left;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] waddr);
        if (waddr == 30'h40) return 32'hDEADBEEF;
        if (waddr == 30'h80) return 32'h80FF0011;
        if (waddr >= 30'h8 && waddr <= 30'hB) return 32'hA0 + 32'(waddr - 30'h8);
        return (32'(waddr) * 32'h9E3779B1) ^ 32'h35C41B07;
    endfunction

    // What a load must return, computed from the byte address with shifts and masks.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int width, input bit sgn);
        logic [31:0] w;
        logic [31:0] v;
        w = mem_word(addr[31:2]);
        if (width == 0) begin
            v = (w >> (int'(addr[1:0]) * 8)) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
        end else if (width == 1) begin
            v = (w >> (int'(addr[1]) * 16)) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input int s, input int w, input int tag, input bit v, input bit d);
        logic [29:0] wa;
        tag_m[s][w]   = 26'(tag);
        valid_m[s][w] = v;
        dirty_m[s][w] = d;
        for (int k = 0; k < BW; k++) begin
            wa = {26'(tag), 2'(s), 2'(k)};
            data_m[s][w][k] = mem_word(wa);
        end
    endtask

    // Cache array and memory unit responder; drives at negedge, observes 1ns later.
    initial begin
        cache_port1_granted_i = 0; cache_hit_i = 0; cache_way_valid_i = '0;
        cache_way_dirty_i = '0; cache_data_i = '0; memory_evict_done_i = 0;
        memory_acknowledge_i = 0; memory_data_i = '0; memory_data_valid_i = 0;
        rd_pend = 0; mem_active = 0; beat_taken = 0; beats_left = 0;
        forever begin
            @(negedge clk_i);
            cache_port1_granted_i = ($urandom_range(99) < grant_pct);
            memory_acknowledge_i  = ($urandom_range(99) < ack_pct);
            memory_evict_done_i   = ($urandom_range(99) < done_pct);
            cmp_cycle = rd_pend;
            rd_pend   = 0;
            if (cmp_cycle) begin
                int s, word, hw;
                s = int'(rd_waddr[3:2]); word = int'(rd_waddr[1:0]); hw = 0;
                cmp_waddr = rd_waddr;
                cmp_hit = 0;
                for (int w = 0; w < WAYS; w++) begin
                    cache_way_valid_i[w] = valid_m[s][w];
                    cache_way_dirty_i[w] = dirty_m[s][w];
                    if (valid_m[s][w] && tag_m[s][w] == rd_waddr[29:4]) begin
                        cmp_hit = 1; hw = w;
                    end
                end
                cache_hit_i  = cmp_hit;
                cache_data_i = cmp_hit ? data_m[s][hw][word] : $urandom;
            end else begin
                cache_hit_i       = 0;
                cache_way_valid_i = WAYS'($urandom);
                cache_way_dirty_i = WAYS'($urandom);
                cache_data_i      = $urandom;
            end
            if (beat_taken) begin
                memory_data_valid_i = 0;
                beat_taken = 0;
            end
            if (mem_active && beats_left > 0) begin
                if (!memory_data_valid_i && !hold_data && $urandom_range(99) < dv_pct) begin
                    memory_data_valid_i = 1;
                    memory_data_i = mem_word(mem_base[31:2] + 30'(beat_idx));
                end
            end else begin
                memory_data_valid_i = 0;
            end
            #1;
            if (cmp_cycle && !kill_i && !cmp_hit) begin
                int s, v;
                s = int'(cmp_waddr[3:2]); v = -1;
                for (int w = 0; w < WAYS; w++) if (!valid_m[s][w] && v < 0) v = w;
                if (v < 0) v = rr_m;
                rr_m       = (rr_m + 1) % WAYS;
                exp_victim = v;
                exp_evict  = valid_m[s][v] && dirty_m[s][v];
                evict_seen = 0;
            end
            if (cache_read_o) begin
                rd_pend  = 1;
                rd_waddr = cache_address_o;
                check_output("read_addr", 32'(cache_address_o), 32'(cur_addr[31:2]));
            end
            if (memory_evict_o && memory_evict_done_i) begin
                check_output("evict_way", 32'(memory_evict_way_o), 32'(1) << exp_victim);
                evict_seen = 1;
                dirty_m[int'(cur_addr[5:4])][exp_victim] = 0;
            end
            if (memory_request_o && memory_acknowledge_i) begin
                logic [31:0] ea;
                ea = cur_cach ? {cur_addr[31:4], 4'b0} : {cur_addr[31:2], 2'b0};
                check_output("mem_addr", memory_address_o, ea);
                if (cur_cach) check_output("evict_before_refill", 32'(evict_seen), 32'(exp_evict));
                mem_active = 1; mem_cach = cur_cach; mem_base = ea;
                beat_idx = 0; beats_left = cur_cach ? BW : 1;
            end
            if (memory_data_valid_i && memory_ready_o) begin
                if (mem_cach) begin
                    int s;
                    s = int'(mem_base[5:4]);
                    check_output("refill_write", 32'(cache_write_o), 32'd1);
                    check_output("refill_enables", 32'(cache_enable_o), 32'hF);
                    check_output("refill_way", 32'(cache_enable_way_o), 32'(1) << exp_victim);
                    check_output("refill_valid_dirty", 32'({cache_valid_o, cache_dirty_o}), 32'b10);
                    check_output("refill_data", cache_data_o, memory_data_i);
                    check_output("refill_addr", 32'(cache_address_o), 32'(mem_base[31:2] + 30'(beat_idx)));
                    tag_m[s][exp_victim]   = mem_base[31:6];
                    valid_m[s][exp_victim] = 1;
                    dirty_m[s][exp_victim] = 0;
                    data_m[s][exp_victim][beat_idx] = memory_data_i;
                end else begin
                    check_output("nc_no_cache_write", 32'(cache_write_o), 32'd0);
                end
                beat_idx++; beats_left--;
                beat_taken = 1;
                if (beats_left == 0) mem_active = 0;
            end else if (cache_write_o) begin
                check_output("spurious_cache_write", 32'(cache_write_o), 32'd0);
            end
        end
    end

    // Scoreboard monitor: every result strobe must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (load_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_valid", 32'(load_valid_o), 32'd0);
                end else begin
                    check_output("load_data", load_data_o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_i);
        while (!idle_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (!idle_o) begin
            vectors++; miscompares++;
            $display("[TB] FAIL idle_timeout: idle_o=%0d after %0d cycles, required 1", idle_o, n);
        end
    endtask

    // Issue one load and hold it until its result or an injected kill.
    task automatic apply_stimulus(input logic [31:0] addr, input int width, input bit sgn,
                                  input bit cach, input int kill_at);
        int  cyc;
        bit  done;
        wait_idle();
        cur_addr        = addr;
        cur_cach        = cach;
        load_address_i  = addr;
        load_width_i    = 2'(width);
        load_signed_i   = sgn;
        load_cachable_i = cach;
        load_read_i     = 1;
        exp_q.push_back(ref_load(addr, width, sgn));
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk_i);
            cyc++;
            if (load_valid_o) begin
                done = 1;
                last_latency = cyc;
            end else if (cyc == kill_at) begin
                kill_i      = 1;
                load_read_i = 0;
                void'(exp_q.pop_back());
                @(negedge clk_i);
                kill_i = 0;
                done   = 1;
            end else if (cyc > 400) begin
                vectors++; miscompares++;
                $display("[TB] FAIL load_timeout: no load_valid_o after %0d cycles, required one", cyc);
                void'(exp_q.pop_back());
                done = 1;
            end
        end
        load_read_i = 0;
    endtask

    // Hard stop so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then randomized loads.
    initial begin
        vectors = 0; miscompares = 0; rr_m = 0;
        kill_i = 0; load_read_i = 0; load_address_i = '0; load_cachable_i = 0;
        load_width_i = 2'd0; load_signed_i = 0; hold_data = 0;
        cur_addr = '0; cur_cach = 0; exp_victim = 0; exp_evict = 0; evict_seen = 0;
        grant_pct = 100; ack_pct = 100; dv_pct = 100; done_pct = 50;
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) set_line(s, w, 0, 0, 0);
        set_line(0, 0, 4, 1, 0); set_line(0, 1, 1, 1, 0);
        set_line(0, 2, 2, 1, 0); set_line(0, 3, 3, 1, 0);
        for (int w = 0; w < WAYS; w++) set_line(3, w, w + 1, 1, 1);
        set_line(2, 0, 1, 1, 0); set_line(2, 1, 2, 1, 0);
        set_line(2, 2, 0, 0, 0); set_line(2, 3, 3, 1, 0);

        rst_n_i = 0;
        repeat (3) @(negedge clk_i);
        check_output("reset_load_valid", 32'(load_valid_o), 32'd0);
        check_output("reset_load_data", load_data_o, 32'd0);
        check_output("reset_idle", 32'(idle_o), 32'd1);
        rst_n_i = 1;
        @(negedge clk_i);
        check_output("reset_port1_req", 32'(port1_request_o), 32'd0);
        check_output("reset_mem_req", 32'(memory_request_o), 32'd0);
        check_output("reset_evict", 32'(memory_evict_o), 32'd0);

        $display("[TB] directed: dirty misses, hit, alignment, clean miss");
        apply_stimulus(32'h174, 2, 0, 1, -1);
        apply_stimulus(32'h1B0, 2, 0, 1, -1);
        apply_stimulus(32'h100, 2, 0, 1, -1);
        check_output("hit_latency", 32'(last_latency), 32'd2);
        apply_stimulus(32'h203, 0, 1, 1, -1);
        apply_stimulus(32'h203, 0, 0, 1, -1);
        apply_stimulus(32'h202, 1, 0, 1, -1);
        apply_stimulus(32'h028, 2, 0, 1, -1);

        $display("[TB] directed: non-cachable load killed in WAIT_WORD");
        begin
            int n;
            wait_idle();
            hold_data = 1;
            cur_addr = 32'h344; cur_cach = 0;
            load_address_i = 32'h344; load_width_i = 2'd2; load_signed_i = 0;
            load_cachable_i = 0; load_read_i = 1;
            n = 0;
            @(negedge clk_i);
            while (!memory_ready_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            check_output("nc_reached_wait", 32'(memory_ready_o), 32'd1);
            kill_i = 1; load_read_i = 0;
            @(negedge clk_i);
            kill_i = 0; hold_data = 0;
            wait_idle();
            check_output("nc_beat_consumed", 32'(beats_left), 32'd0);
        end

        $display("[TB] random phase");
        grant_pct = 70; ack_pct = 60; dv_pct = 70; done_pct = 40;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int          kat;
            if ($urandom_range(99) < 30) begin
                int s, w;
                s = $urandom_range(NSETS - 1); w = $urandom_range(WAYS - 1);
                if (valid_m[s][w]) dirty_m[s][w] = 1;
            end
            a = {23'b0, 3'($urandom_range(7)), 2'($urandom), 2'($urandom), 2'($urandom)};
            kat = ($urandom_range(99) < 15) ? int'($urandom_range(8, 1)) : -1;
            apply_stimulus(a, $urandom_range(2), 1'($urandom), ($urandom_range(99) < 85), kat);
        end

        wait_idle();
        repeat (3) @(negedge clk_i);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
